// File: rtl/alu_wb_sequencer_if.sv
// Instruction handshake, register-bank read/write port and status pulses of alu_wb_sequencer.
// master is the sequencer's view; slave is the instruction source / register bank side.
interface alu_wb_sequencer_if #(
  parameter int DW = 32,
  parameter int AW = 5
) ();
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_sr1;
  logic [AW-1:0] in_sr2;
  logic [AW-1:0] in_dr;
  logic [AW-1:0] sr1;
  logic [AW-1:0] sr2;
  logic [DW-1:0] rdData1;
  logic [DW-1:0] rdData2;
  logic          write;
  logic [AW-1:0] dr;
  logic [DW-1:0] wrData;
  logic          done;
  logic          err;

  modport master (
    input  in_valid, in_op, in_sr1, in_sr2, in_dr, rdData1, rdData2,
    output in_ready, sr1, sr2, write, dr, wrData, done, err
  );

  modport slave (
    output in_valid, in_op, in_sr1, in_sr2, in_dr, rdData1, rdData2,
    input  in_ready, sr1, sr2, write, dr, wrData, done, err
  );
endinterface

// File: rtl/alu_wb_sequencer.sv
// Execute/writeback sequencer: fetches two bank operands, runs the ALU, writes one result back.
// Optional macro ALU_MUL_EN adds an iterative shift-add multiplier on opcode 8.
module alu_wb_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic                clk,
  input logic                reset,
  alu_wb_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd15;
`ifdef ALU_MUL_EN
  localparam logic [3:0]    OP_MUL   = 4'd8;
  localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
`endif

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLT, OP_SLL, OP_SRL, OP_PASS, OP_NOP: ok = 1'b1;
`ifdef ALU_MUL_EN
      OP_MUL:  ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [DW-1:0] alu_calc(input logic [3:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : {DW{1'b0}};
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_PASS: r = a;
      default: r = {DW{1'b0}};
    endcase
    return r;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    op_r;
  logic [DW-1:0] opa_r;
  logic [DW-1:0] opb_r;
  logic [AW-1:0] sr1_r;
  logic [AW-1:0] sr2_r;
  logic [AW-1:0] dr_r;
  logic [DW-1:0] wrdata_r;
  logic          write_r;
  logic          done_r;
  logic          err_r;
  logic          ld_in_s;
  logic          ld_ops_s;
  logic          fin_s;
  logic          write_s;
  logic          err_s;
  logic [DW-1:0] result_s;
`ifdef ALU_MUL_EN
  logic [DW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic          mul_step_s;
  logic [DW-1:0] mul_sum_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_s  = state_r;
    ld_in_s  = 1'b0;
    ld_ops_s = 1'b0;
    fin_s    = 1'b0;
`ifdef ALU_MUL_EN
    mul_step_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          ld_in_s = 1'b1;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ld_ops_s = 1'b1;
        state_s  = ST_EXEC;
      end
      ST_EXEC: begin
`ifdef ALU_MUL_EN
        if (op_r == OP_MUL) begin
          mul_step_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            fin_s   = 1'b1;
            state_s = ST_WB;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          fin_s   = 1'b1;
          state_s = ST_WB;
        end
`else
        fin_s   = 1'b1;
        state_s = ST_WB;
`endif
      end
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Result and writeback qualifiers for the instruction currently in EXEC
  always_comb begin
    err_s = ~op_legal(op_r);
    if (op_legal(op_r) && (op_r != OP_NOP)) begin
      write_s = 1'b1;
    end else begin
      write_s = 1'b0;
    end
`ifdef ALU_MUL_EN
    mul_sum_s = acc_r + (opb_r[0] ? opa_r : {DW{1'b0}});
    if (op_r == OP_MUL) begin
      result_s = mul_sum_s;
    end else begin
      result_s = alu_calc(op_r, opa_r, opb_r);
    end
`else
    result_s = alu_calc(op_r, opa_r, opb_r);
`endif
  end

  // Datapath registers; writeback pulses last exactly the one WB cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r     <= 4'd0;
      opa_r    <= {DW{1'b0}};
      opb_r    <= {DW{1'b0}};
      sr1_r    <= {AW{1'b0}};
      sr2_r    <= {AW{1'b0}};
      dr_r     <= {AW{1'b0}};
      wrdata_r <= {DW{1'b0}};
      write_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_r    <= {DW{1'b0}};
      cnt_r    <= {CW{1'b0}};
`endif
    end else begin
      if (ld_in_s) begin
        op_r  <= bus.in_op;
        dr_r  <= bus.in_dr;
        sr1_r <= bus.in_sr1;
        sr2_r <= bus.in_sr2;
      end
      if (ld_ops_s) begin
        opa_r <= bus.rdData1;
        opb_r <= bus.rdData2;
`ifdef ALU_MUL_EN
        acc_r <= {DW{1'b0}};
        cnt_r <= {CW{1'b0}};
`endif
      end
`ifdef ALU_MUL_EN
      // One partial product per EXEC cycle: multiplicand shifts up, multiplier shifts down
      if (mul_step_s) begin
        acc_r <= mul_sum_s;
        opa_r <= opa_r << 1;
        opb_r <= opb_r >> 1;
        cnt_r <= cnt_r + CW'(1);
      end
`endif
      if (fin_s) begin
        wrdata_r <= result_s;
        write_r  <= write_s;
        done_r   <= 1'b1;
        err_r    <= err_s;
      end else begin
        write_r  <= 1'b0;
        done_r   <= 1'b0;
        err_r    <= 1'b0;
      end
    end
  end

  assign bus.in_ready = (state_r == ST_IDLE);
  assign bus.sr1      = sr1_r;
  assign bus.sr2      = sr2_r;
  assign bus.dr       = dr_r;
  assign bus.wrData   = wrdata_r;
  assign bus.write    = write_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Self-checking bench for alu_wb_sequencer: register bank, instruction-level reference model,
// per-cycle output comparison, directed scenarios and a randomized instruction stream.
`timescale 1ns/1ps
module tb_alu_wb_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_wb_sequencer_if #(.DW(DW), .AW(AW)) bus ();
  alu_wb_sequencer #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Register bank: combinational reads, write at posedge; pre_* loads values while idle
  logic [DW-1:0] bank [32];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  assign bus.rdData1 = bank[bus.sr1];
  assign bus.rdData2 = bank[bus.sr2];
  always @(posedge clk) begin
    if (bus.write) bank[bus.dr] <= bus.wrData;
    if (pre_we) bank[pre_addr] <= pre_data;
  end

  // Reference model state
  logic [DW-1:0] ref_regs [32];
  int            cyc = 0;
  int            wb_cyc = 0;
  bit            pending = 1'b0;
  bit            started = 1'b0;
  bit            e_w, e_err;
  logic [AW-1:0] e_dr, e_s1, e_s2;
  logic [DW-1:0] e_res;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Instruction semantics: result, write/err flags, and edges from accept to the WB cycle
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output bit w, output bit er, output logic [31:0] r, output int lat);
    w = 1'b1; er = 1'b0; lat = 2; r = 32'd0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: begin
`ifdef ALU_MUL_EN
        r = a * b;
        lat = DW + 1;
`else
        w = 1'b0; er = 1'b1;
`endif
      end
      4'd9:  r = a;
      4'd15: w = 1'b0;
      default: begin w = 1'b0; er = 1'b1; end
    endcase
  endfunction

  // Model: commits the finished instruction, then accepts a new one if it was idle
  always @(posedge clk) begin : model_p
    bit rdy, w, er;
    logic [31:0] r;
    int lat;
    rdy = !pending;
    if (!reset) begin
      pending = 1'b0;
      started = 1'b1;
    end else begin
      if (pending && cyc == wb_cyc) begin
        if (e_w) ref_regs[e_dr] = e_res;
        pending = 1'b0;
      end
      if (pre_we) ref_regs[pre_addr] = pre_data;
      if (started && rdy && bus.in_valid) begin
        model_alu(bus.in_op, ref_regs[bus.in_sr1], ref_regs[bus.in_sr2], w, er, r, lat);
        e_w = w; e_err = er; e_res = r;
        e_dr = bus.in_dr; e_s1 = bus.in_sr1; e_s2 = bus.in_sr2;
        pending = 1'b1;
        wb_cyc = cyc + 1 + lat;
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : cmp_p
    bit wb;
    if (started) begin
      wb = pending && (cyc == wb_cyc);
      check1("in_ready", bus.in_ready, !pending);
      check1("done", bus.done, wb);
      check1("write", bus.write, wb && e_w);
      check1("err", bus.err, wb && e_err);
      if (wb && e_w) begin
        check("dr", 32'(bus.dr), 32'(e_dr));
        check("wrData", bus.wrData, e_res);
      end
      if (pending) begin
        check("sr1", 32'(bus.sr1), 32'(e_s1));
        check("sr2", 32'(bus.sr2), 32'(e_s2));
      end
    end
  end

  task automatic load(input int addr, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = AW'(addr); pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input int s1, input int s2, input int d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op;
    bus.in_sr1 = AW'(s1); bus.in_sr2 = AW'(s2); bus.in_dr = AW'(d);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check1("accept_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (pending && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pending) check1("drain_timeout", pending, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 4'd0;
    bus.in_sr1 = 5'd0; bus.in_sr2 = 5'd0; bus.in_dr = 5'd0;
    pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_write", bus.write, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check("rst_wrData", bus.wrData, 32'd0);
    check("rst_sr1", 32'(bus.sr1), 32'd0);

    for (int k = 0; k < 32; k++) load(k, 32'(10 * k));

    issue(4'd1, 2, 5, 6);                       // SUB 20-50
    drain();
    check("sub_reg6", bank[6], 32'hFFFF_FFE2);
    issue(4'd5, 2, 5, 11);                      // SLT 20<50
    issue(4'd5, 5, 2, 12);                      // SLT 50<20
    drain();
    check("slt_reg11", bank[11], 32'd1);
    check("slt_reg12", bank[12], 32'd0);
    issue(4'd0, 3, 4, 5);                       // ADD 30+40
    drain();
    check("add_reg5", bank[5], 32'd70);
    load(20, 32'h8000_0000);
    load(21, 32'd4);
    issue(4'd7, 20, 21, 22);                    // SRL
    drain();
    check("srl_reg22", bank[22], 32'h0800_0000);

    issue(4'd0, 1, 1, 1);                       // dependent back-to-back, valid held
    issue(4'd0, 1, 1, 1);
    issue(4'd0, 1, 1, 1);
    drain();
    check("raw_reg1", bank[1], 32'd80);

    issue(4'd0, 3, 4, 7);                       // reset while in EXEC
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check1("midrst_write", bus.write, 1'b0);
    check1("midrst_done", bus.done, 1'b0);
    check1("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_sr1", 32'(bus.sr1), 32'd0);
    check("midrst_dr", 32'(bus.dr), 32'd0);
    check("midrst_wrData", bus.wrData, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_reg7", bank[7], 32'd70);

    issue(4'd12, 2, 3, 13);                     // illegal
    issue(4'd15, 1, 2, 14);                     // NOP
    drain();
    check("illegal_reg13", bank[13], 32'd130);
    check("nop_reg14", bank[14], 32'd140);

    issue(4'd8, 7, 9, 8);                       // MUL 70*90
    drain();
`ifdef ALU_MUL_EN
    check("mul_reg8", bank[8], 32'd6300);
`else
    check("mul_reg8", bank[8], 32'd80);
`endif

    for (int k = 0; k < 32; k++) load(k, $urandom);
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    drain();
    for (int k = 0; k < 32; k++) check("final_bank", bank[k], ref_regs[k]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_wb_sequencer.md
Name: alu_wb_sequencer

Overview:
Execute/writeback stage that consumes the 32x32 register bank's read ports and produces its write port. Accepts one register-register instruction per handshake, drives sr1/sr2 to the bank, captures rdData1/rdData2, computes the result and issues a single-cycle write (write/dr/wrData) back to the bank. A sequential FSM guarantees each write commits before the next operand fetch, so no hazard logic is needed.

Parameters:
DW, 32, datapath width; equals register bank data width
AW, 5, register address width; 2**AW registers

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low; 0 at a posedge clears all state
in_valid  input  1  instruction offered
in_ready  output  1  sequencer can accept; high only in IDLE
in_op  input  4  opcode
in_sr1  input  AW  source register A
in_sr2  input  AW  source register B
in_dr  input  AW  destination register
sr1  output  AW  to bank read port 1 (registered)
sr2  output  AW  to bank read port 2 (registered)
rdData1  input  DW  from bank, combinational read of sr1
rdData2  input  DW  from bank, combinational read of sr2
write  output  1  bank write enable (registered)
dr  output  AW  bank write address (registered)
wrData  output  DW  bank write data (registered)
done  output  1  one-cycle pulse in WB, every instruction
err  output  1  one-cycle pulse in WB for illegal opcode

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; sr1, sr2, dr, wrData, write, done, err, internal opA/opB/op/counter = 0. in_ready = (state==IDLE), hence 1 from the first cycle after reset.
- Reset mid-operation: the instruction in flight is abandoned; no write is issued, not even when reset lands in WB. Write must already be 0 in the cycle after the reset edge.
- FSM: IDLE -> FETCH -> EXEC -> WB -> IDLE. MUL stays in EXEC for DW cycles.
- IDLE: when in_valid&&in_ready at a posedge, latch op and dr, load sr1<=in_sr1 and sr2<=in_sr2, go to FETCH. in_valid without in_ready: instruction is held by the source and not consumed.
- FETCH: sr1/sr2 are stable. Capture opA<=rdData1 and opB<=rdData2 at the posedge, then go to EXEC.
- EXEC: compute the result into wrData. Single-cycle ops go to WB next.
- WB: exactly one cycle. done=1. write=1 unless op is NOP or illegal. The bank commits at the posedge ending WB. Then go to IDLE.
- Latency: accept at edge E0. write is high during the cycle after edge E2 and commits at E3. Back-to-back throughput is 1 instruction per 4 cycles (MUL: DW+3).
- RAW dependency: an instruction accepted after WB reads the new value. No bypass is required.
- Opcodes, all results truncated to DW bits:
  0 ADD a+b
  1 SUB a-b (two's complement)
  2 AND
  3 OR
  4 XOR
  5 SLT: signed a<b gives 1, else 0
  6 SLL a<<b[4:0]
  7 SRL a>>b[4:0] (logical)
  8 MUL (optional feature)
  9 PASS a
  15 NOP: done pulses, no write, err=0
  10-14 illegal: no write, err=1 with done
- dr == sr1 or sr2 is legal: operands are captured before the write.
- write, err and done are never high outside WB.

Optional Feature:
ALU_MUL_EN:
- Defined: op 8 runs an iterative shift-add multiply in EXEC with a counter of DW cycles. The result is the low DW bits of a*b, unsigned. The counter is cleared by reset and on entering EXEC.
- Undefined: op 8 is illegal (no write, err=1 in WB) and the multiplier/counter logic is absent.

Test Plan:
1. Preload reg[k]=10*k, then ADD sr1=3 sr2=4 dr=5 accepted at E0 -> write=1, dr=5, wrData=70 in the cycle after E2, done=1. Subsequent read of reg[5]=70.
2. SUB 2,5 -> dr=6 gives 0xFFFFFFE2. SLT 2,5 gives 1. SLT 5,2 gives 0. SRL reg=0x80000000 by 4 gives 0x08000000.
3. Dependent back-to-back ADD 1,1->dr=1 three times (reg1 initially 10) with in_valid held high -> accepts every 4th edge, reg1 = 20, 40, 80; in_ready low in FETCH/EXEC/WB.
4. reset=0 during EXEC of ADD 3,4->dr=7 -> no write pulse and reg7 stays 70. in_ready=1 one cycle after the reset edge; all outputs 0.
5. op=12 -> done=1, err=1, write=0. op=15 -> done=1, err=0, write=0.
6. MUL 7,9 -> dr=8: with ALU_MUL_EN, wrData=6300 with write in WB at DW+3 cycles after accept. Without ALU_MUL_EN, err=1 at the 4th cycle and reg8 is unchanged.
